// File: rtl/register_file_mp_pkg.sv
// Shared constants and helpers for the multi-port MIPS register file.
// Write-port indices double as priority: the higher index is applied last and wins.
package register_file_mp_pkg;

   localparam int MIPS_DATA_W   = 32;
   localparam int MIPS_DEPTH    = 32;

   localparam int WR_PORT_WB    = 0;
   localparam int WR_PORT_LOAD  = 1;
   localparam int NUM_WR_PORTS  = 2;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Bus bundle between the pipeline (master) and the register file (slave).
interface register_file_mp_if #(
   parameter int DATA_W = 32,
   parameter int AW     = 5,
   parameter int NUM_RD = 2
);
   logic                       we0;
   logic [AW-1:0]              waddr0;
   logic [DATA_W-1:0]          wdata0;
   logic                       we1;
   logic [AW-1:0]              waddr1;
   logic [DATA_W-1:0]          wdata1;
   logic [NUM_RD*AW-1:0]       raddr;
   logic [NUM_RD*DATA_W-1:0]   rdata;
   logic [NUM_RD-1:0]          rbusy;
   logic                       busy_set;
   logic [AW-1:0]              busy_addr;

   modport master (
      output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, busy_set, busy_addr,
      input  rdata, rbusy
   );

   modport slave (
      input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, busy_set, busy_addr,
      output rdata, rbusy
   );
endinterface

// File: rtl/register_file_mp_rf_read_port.sv
// One combinational read port: r0 masking, write-to-read bypass and busy masking.
module rf_read_port #(
   parameter int DATA_W  = 32,
   parameter int AW      = 5,
   parameter bit ZERO_R0 = 1'b1
) (
   input  logic [AW-1:0]     addr_i,
   input  logic              we0_i,
   input  logic [AW-1:0]     waddr0_i,
   input  logic [DATA_W-1:0] wdata0_i,
   input  logic              we1_i,
   input  logic [AW-1:0]     waddr1_i,
   input  logic [DATA_W-1:0] wdata1_i,
   input  logic [DATA_W-1:0] mem_word_i,
   input  logic              busy_bit_i,
   output logic [DATA_W-1:0] data_o,
   output logic              busy_o
);

   // A bypassed value is the one the pending producer will deliver, so it is never busy.
   always_comb begin
      data_o = mem_word_i;
      busy_o = busy_bit_i;
      if (ZERO_R0 && addr_i == '0) begin
         data_o = '0;
         busy_o = 1'b0;
      end else if (we1_i && waddr1_i == addr_i) begin
         data_o = wdata1_i;
         busy_o = 1'b0;
      end else if (we0_i && waddr0_i == addr_i) begin
         data_o = wdata0_i;
         busy_o = 1'b0;
      end
   end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: storage, two write ports, busy scoreboard and N bypassing read ports.
module register_file_mp
   import register_file_mp_pkg::*;
#(
   parameter int DATA_W  = MIPS_DATA_W,
   parameter int DEPTH   = MIPS_DEPTH,
   parameter int NUM_RD  = 2,
   parameter bit ZERO_R0 = 1'b1
) (
   input logic                 clk,
   input logic                 rst,
   register_file_mp_if.slave   rf
);

   localparam int AW = clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;

   logic              wr_en   [NUM_WR_PORTS];
   logic [AW-1:0]     wr_addr [NUM_WR_PORTS];
   logic [DATA_W-1:0] wr_data [NUM_WR_PORTS];

   logic [DATA_W-1:0] rd_data [NUM_RD];
   logic              rd_busy [NUM_RD];

   always_comb begin
      wr_en[WR_PORT_WB]     = rf.we0;
      wr_addr[WR_PORT_WB]   = rf.waddr0;
      wr_data[WR_PORT_WB]   = rf.wdata0;
      wr_en[WR_PORT_LOAD]   = rf.we1;
      wr_addr[WR_PORT_LOAD] = rf.waddr1;
      wr_data[WR_PORT_LOAD] = rf.wdata1;
   end

   // Clears first, then the set, so a newly issued producer overrides a retiring one.
   always_comb begin
      busy_d = busy_q;
      for (int p = 0; p < NUM_WR_PORTS; p++) begin
         if (wr_en[p]) busy_d[wr_addr[p]] = 1'b0;
      end
      if (rf.busy_set && !(ZERO_R0 && rf.busy_addr == '0)) busy_d[rf.busy_addr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         busy_q <= '0;
      end else begin
         // Ports applied in index order: the load-return port lands last on a collision.
         for (int p = 0; p < NUM_WR_PORTS; p++) begin
            if (wr_en[p] && !(ZERO_R0 && wr_addr[p] == '0)) mem_q[wr_addr[p]] <= wr_data[p];
         end
         busy_q <= busy_d;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0] addr;
      assign addr = rf.raddr[k*AW +: AW];

      rf_read_port #(
         .DATA_W  (DATA_W),
         .AW      (AW),
         .ZERO_R0 (ZERO_R0)
      ) u_port (
         .addr_i     (addr),
         .we0_i      (rf.we0),
         .waddr0_i   (rf.waddr0),
         .wdata0_i   (rf.wdata0),
         .we1_i      (rf.we1),
         .waddr1_i   (rf.waddr1),
         .wdata1_i   (rf.wdata1),
         .mem_word_i (mem_q[addr]),
         .busy_bit_i (busy_q[addr]),
         .data_o     (rd_data[k]),
         .busy_o     (rd_busy[k])
      );
   end

   always_comb begin
      rf.rdata = '0;
      rf.rbusy = '0;
      if (rst) begin
         for (int k = 0; k < NUM_RD; k++) begin
            rf.rdata[k*DATA_W +: DATA_W] = rd_data[k];
            rf.rbusy[k]                  = rd_busy[k];
         end
      end
   end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed and random checks of register_file_mp against an array-based reference model.
module tb_register_file_mp;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NA = 4;
   localparam int NB = 2;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   register_file_mp_if #(.DATA_W(DW), .AW(AW), .NUM_RD(NA)) ifa ();
   register_file_mp_if #(.DATA_W(DW), .AW(AW), .NUM_RD(NB)) ifb ();

   register_file_mp #(.DATA_W(DW), .DEPTH(32), .NUM_RD(NA), .ZERO_R0(1'b1)) dut_a (
      .clk (clk), .rst (rst), .rf (ifa.slave));

   register_file_mp #(.DATA_W(DW), .DEPTH(32), .NUM_RD(NB), .ZERO_R0(1'b0)) dut_b (
      .clk (clk), .rst (rst), .rf (ifb.slave));

   assign ifb.we0       = ifa.we0;
   assign ifb.waddr0    = ifa.waddr0;
   assign ifb.wdata0    = ifa.wdata0;
   assign ifb.we1       = ifa.we1;
   assign ifb.waddr1    = ifa.waddr1;
   assign ifb.wdata1    = ifa.wdata1;
   assign ifb.busy_set  = ifa.busy_set;
   assign ifb.busy_addr = ifa.busy_addr;

   // Model index 0 = ZERO_R0 instance, 1 = plain instance.
   logic [31:0] m_mem  [2][32];
   bit          m_busy [2][32];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rda(input int k);
      return ifa.rdata[k*DW +: DW];
   endfunction

   function automatic logic [31:0] rdb(input int k);
      return ifb.rdata[k*DW +: DW];
   endfunction

   function automatic void mdl_read(input int inst, input int a,
                                    output logic [31:0] d, output logic b);
      d = m_mem[inst][a];
      b = m_busy[inst][a];
      if (!rst) begin
         d = 0; b = 0;
      end else if (inst == 0 && a == 0) begin
         d = 0; b = 0;
      end else if (ifa.we1 && int'(ifa.waddr1) == a) begin
         d = ifa.wdata1; b = 0;
      end else if (ifa.we0 && int'(ifa.waddr0) == a) begin
         d = ifa.wdata0; b = 0;
      end
   endfunction

   task automatic mdl_update();
      for (int m = 0; m < 2; m++) begin
         if (!rst) begin
            for (int i = 0; i < 32; i++) begin
               m_mem[m][i] = 0; m_busy[m][i] = 0;
            end
         end else begin
            if (ifa.we0) begin
               m_mem[m][ifa.waddr0] = ifa.wdata0; m_busy[m][ifa.waddr0] = 0;
            end
            if (ifa.we1) begin
               m_mem[m][ifa.waddr1] = ifa.wdata1; m_busy[m][ifa.waddr1] = 0;
            end
            if (ifa.busy_set && !(m == 0 && ifa.busy_addr == 0)) m_busy[m][ifa.busy_addr] = 1;
         end
      end
   endtask

   task automatic mdl_check();
      logic [31:0] d;
      logic        b;
      for (int k = 0; k < NA; k++) begin
         mdl_read(0, int'(ifa.raddr[k*AW +: AW]), d, b);
         chk($sformatf("mdl_a_data%0d", k), rda(k), d);
         chk($sformatf("mdl_a_busy%0d", k), {31'b0, ifa.rbusy[k]}, {31'b0, b});
      end
      for (int k = 0; k < NB; k++) begin
         mdl_read(1, int'(ifb.raddr[k*AW +: AW]), d, b);
         chk($sformatf("mdl_b_data%0d", k), rdb(k), d);
         chk($sformatf("mdl_b_busy%0d", k), {31'b0, ifb.rbusy[k]}, {31'b0, b});
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      mdl_check();
      @(posedge clk);
      mdl_update();
      #1;
   endtask

   task automatic idle();
      ifa.we0 = 0; ifa.waddr0 = 0; ifa.wdata0 = 0;
      ifa.we1 = 0; ifa.waddr1 = 0; ifa.wdata1 = 0;
      ifa.busy_set = 0; ifa.busy_addr = 0;
   endtask

   task automatic set_raddr_all(input int a);
      for (int k = 0; k < NA; k++) ifa.raddr[k*AW +: AW] = AW'(a);
      for (int k = 0; k < NB; k++) ifb.raddr[k*AW +: AW] = AW'(a);
   endtask

   initial begin
      for (int m = 0; m < 2; m++)
         for (int i = 0; i < 32; i++) begin
            m_mem[m][i] = 0; m_busy[m][i] = 0;
         end
      rst = 0;
      idle();
      set_raddr_all(0);
      cycle();
      cycle();
      rst = 1;

      // Reset behaviour
      set_raddr_all(5);
      ifa.we0 = 1; ifa.waddr0 = 5; ifa.wdata0 = 32'h1234;
      ifa.busy_set = 1; ifa.busy_addr = 5;
      cycle();
      idle();
      #1;
      chk("pre_rst_data", rda(0), 32'h1234);
      chk("pre_rst_busy", {31'b0, ifa.rbusy[0]}, 32'd1);
      rst = 0;
      ifa.we0 = 1; ifa.waddr0 = 5; ifa.wdata0 = 32'h7777;
      #1;
      chk("in_rst_data", rda(0), 32'h0);
      chk("in_rst_busy", {31'b0, ifa.rbusy[0]}, 32'd0);
      cycle();
      idle();
      rst = 1;
      #1;
      chk("post_rst_data", rda(0), 32'h0);
      chk("post_rst_busy", {31'b0, ifa.rbusy[0]}, 32'd0);

      // Write then read, bypass and stored
      set_raddr_all(8);
      ifa.we0 = 1; ifa.waddr0 = 8; ifa.wdata0 = 32'hA5A5A5A5;
      #1;
      for (int k = 0; k < NA; k++) chk($sformatf("wr_bypass%0d", k), rda(k), 32'hA5A5A5A5);
      cycle();
      idle();
      #1;
      chk("wr_stored", rda(0), 32'hA5A5A5A5);
      cycle();
      chk("wr_stored_later", rda(0), 32'hA5A5A5A5);

      // Write-port collision
      set_raddr_all(9);
      ifa.we0 = 1; ifa.waddr0 = 9; ifa.wdata0 = 32'h11111111;
      ifa.we1 = 1; ifa.waddr1 = 9; ifa.wdata1 = 32'h22222222;
      #1;
      chk("coll_bypass", rda(0), 32'h22222222);
      cycle();
      idle();
      #1;
      chk("coll_stored", rda(0), 32'h22222222);

      // Zero register
      set_raddr_all(0);
      ifa.we0 = 1; ifa.waddr0 = 0; ifa.wdata0 = 32'hFFFFFFFF;
      ifa.busy_set = 1; ifa.busy_addr = 0;
      #1;
      chk("r0_bypass_a", rda(0), 32'h0);
      chk("r0_bypass_b", rdb(0), 32'hFFFFFFFF);
      cycle();
      idle();
      #1;
      chk("r0_data_a", rda(0), 32'h0);
      chk("r0_busy_a", {31'b0, ifa.rbusy[0]}, 32'd0);
      chk("r0_data_b", rdb(0), 32'hFFFFFFFF);
      chk("r0_busy_b", {31'b0, ifb.rbusy[0]}, 32'd1);

      // Scoreboard
      set_raddr_all(10);
      ifa.busy_set = 1; ifa.busy_addr = 10;
      #1;
      chk("sb_t0_busy", {31'b0, ifa.rbusy[0]}, 32'd0);
      cycle();
      idle();
      #1;
      chk("sb_t1_busy", {31'b0, ifa.rbusy[0]}, 32'd1);
      cycle();
      ifa.we1 = 1; ifa.waddr1 = 10; ifa.wdata1 = 32'hCAFEF00D;
      #1;
      chk("sb_t2_busy", {31'b0, ifa.rbusy[0]}, 32'd0);
      chk("sb_t2_data", rda(0), 32'hCAFEF00D);
      cycle();
      idle();
      #1;
      chk("sb_cleared", {31'b0, ifa.rbusy[0]}, 32'd0);
      ifa.busy_set = 1; ifa.busy_addr = 10;
      ifa.we0 = 1; ifa.waddr0 = 10; ifa.wdata0 = 32'h12345678;
      cycle();
      idle();
      #1;
      chk("sb_set_wins", {31'b0, ifa.rbusy[0]}, 32'd1);

      // Multi-port reads with duplicates
      ifa.we0 = 1; ifa.waddr0 = 9; ifa.wdata0 = 32'h5A5A5A5A;
      cycle();
      idle();
      ifa.raddr = {5'd0, 5'd8, 5'd9, 5'd8};
      #1;
      chk("mp_port0", rda(0), 32'hA5A5A5A5);
      chk("mp_port1", rda(1), 32'h5A5A5A5A);
      chk("mp_port2", rda(2), 32'hA5A5A5A5);
      chk("mp_port3", rda(3), 32'h0);
      ifa.we1 = 1; ifa.waddr1 = 8; ifa.wdata1 = 32'hDEADBEEF;
      #1;
      chk("mp_byp0", rda(0), 32'hDEADBEEF);
      chk("mp_byp1", rda(1), 32'h5A5A5A5A);
      chk("mp_byp2", rda(2), 32'hDEADBEEF);
      chk("mp_byp3", rda(3), 32'h0);
      cycle();
      idle();

      // Random traffic over a narrow address range to force collisions
      for (int n = 0; n < 400; n++) begin
         rst          = ($urandom_range(0, 31) != 0);
         ifa.we0      = $urandom_range(0, 1);
         ifa.waddr0   = AW'($urandom_range(0, 7));
         ifa.wdata0   = $urandom;
         ifa.we1      = ($urandom_range(0, 2) == 0);
         ifa.waddr1   = AW'($urandom_range(0, 7));
         ifa.wdata1   = $urandom;
         ifa.busy_set = $urandom_range(0, 1);
         ifa.busy_addr = AW'($urandom_range(0, 7));
         for (int k = 0; k < NA; k++) ifa.raddr[k*AW +: AW] = AW'($urandom_range(0, 7));
         for (int k = 0; k < NB; k++) ifb.raddr[k*AW +: AW] = AW'($urandom_range(0, 7));
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
